if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Fetch-sequencing controller for the Instruction Fetch stage. It owns the PC and runs a req/ack handshake to a variable-latency instruction memory. It drives the freeze/flush controls and the PC/instruction inputs of the IF/ID pipeline register. Hazard stalls, bubbles while a fetch is outstanding, and taken branches from EXE are resolved here, including a branch that arrives while a memory request is still in flight.

## Interface
- ADDR_W, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC after reset
- NOP_INSTR, 32'hE000_0000, instruction presented on fetch_instr when no valid instruction is buffered
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- hazard  in  1  downstream stall request; IF/ID must hold
- branch_taken  in  1  single-cycle pulse from EXE: redirect fetch
- branch_addr  in  ADDR_W  redirect target, valid when branch_taken=1
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_W  request address; stable while imem_req=1
- imem_ack  in  1  single-cycle completion; sampled only while imem_req=1; may be asserted in the first req cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- fetch_pc  out  ADDR_W  PC+4 of buffered instruction (IF/ID PC input)
- fetch_instr  out  32  buffered instruction, or NOP_INSTR (IF/ID instruction input)
- ifid_freeze  out  1  hold IF/ID contents this edge
- ifid_flush  out  1  load NOP into IF/ID this edge (effective only when ifid_freeze=0)

## Operation
- Registers: pc, req_addr, instr_buf, 2-bit state. States: S_REQ, S_HAVE, S_DRAIN.
- S_REQ:
  - imem_req=1, imem_addr=req_addr (equal to pc).
  - On imem_ack: instr_buf<=imem_rdata, go to S_HAVE.
  - Outputs: ifid_freeze=hazard, ifid_flush=!hazard (bubble).
- S_HAVE:
  - imem_req=0, fetch_instr=instr_buf, fetch_pc=pc+4.
  - hazard=1: freeze=1, flush=0, stay in S_HAVE.
  - hazard=0: freeze=0, flush=0. IF/ID loads on this edge; pc<=pc+4, req_addr<=pc+4, go to S_REQ.
- S_DRAIN:
  - imem_req=1, imem_addr=req_addr (the stale address). freeze=hazard, flush=!hazard.
  - On imem_ack: data is discarded; req_addr<=pc, go to S_REQ.
- branch_taken=1 has priority over hazard and over every state. It forces freeze=0 and flush=1 for that cycle, and pc<=branch_addr.
  - In S_HAVE, or in S_REQ with imem_ack=1 the same cycle: buffered/returned word is dropped; req_addr<=branch_addr, go to S_REQ.
  - In S_REQ without ack: go to S_DRAIN. req_addr is unchanged, so the outstanding request completes at its original address.
  - In S_DRAIN: pc<=branch_addr only, stay in S_DRAIN; the later target wins. If ack arrives the same cycle, go to S_REQ with req_addr<=branch_addr.
- In any state other than S_HAVE, fetch_instr=NOP_INSTR and fetch_pc=0.
- PC arithmetic is modulo 2^ADDR_W; pc+4 wraps from 0xFFFF_FFFC to 0. branch_addr is used unmodified.

## Timing
- rst=1 at an edge: pc=req_addr=RESET_PC, instr_buf=NOP_INSTR, state=S_REQ.
- While rst=1, outputs are forced to: imem_req=0, ifid_freeze=0, ifid_flush=1, fetch_instr=NOP_INSTR, fetch_pc=0.
- Reset mid-request abandons the transaction; instruction memory shares rst.
- First imem_req=1 occurs in the first cycle with rst=0.
- Zero-wait memory: request in cycle N, instruction on fetch_* in N+1, IF/ID loads at end of N+1, next request in N+2. Peak throughput is 1 instruction per 2 cycles.
- Memory with k wait cycles adds k cycles per fetch.
- All outputs are combinational from state/registers plus hazard, branch_taken and rst. There is no combinational path from imem_rdata to any output.

## Configuration
- IF_FETCH_CTRL_PERF_EN defined: adds outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_fetch_cnt increments on every IF/ID load of a valid instruction (S_HAVE, hazard=0, branch_taken=0).
  - perf_stall_cnt increments every cycle with ifid_freeze=1.
  - Both counters reset to 0 and wrap at 2^32.
- IF_FETCH_CTRL_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with zero-wait memory (ack tied to req): imem_addr sequence 0,4,8,... on alternate cycles. fetch_pc 4,8,12 on S_HAVE cycles, ifid_flush=1 on S_REQ cycles.
- 3-wait-cycle memory, hazard=1 for 5 cycles while in S_HAVE: freeze=1 for exactly those cycles. instr_buf is held and pc is unchanged; the next imem_addr is pc+4 after hazard drops.
- branch_taken with branch_addr=0x100 while in S_HAVE with hazard=1: flush=1, freeze=0 that cycle. The next request is to 0x100 and the buffered word never reaches IF/ID.
- branch_taken (0x200) in S_REQ at wait cycle 1 of 3: imem_addr stays at the old address until ack, and the returned word is discarded. The next request is to 0x200, and ifid_flush=1 throughout.
- Second branch (0x300) during S_DRAIN, then branch coincident with ack: the final request goes to the latest target only.
- With IF_FETCH_CTRL_PERF_EN, fetch 10 instructions with 4 hazard cycles: perf_fetch_cnt=10, perf_stall_cnt=4. Assert rst mid-request: counters are 0 and imem_req=0 while rst=1, then a request to RESET_PC follows.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer: PC, imem req/ack, IF/ID freeze/flush control.
// Optional performance counters are enabled with `define IF_FETCH_CTRL_PERF_EN.
module if_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'hE000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              ifid_freeze,
    output logic              ifid_flush
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HAVE  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_instr_buf;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_pc_next = r_pc + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_instr_buf <= NOP_INSTR;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (branch_taken) begin
                        r_pc <= branch_addr;
                        // Without ack the request is still in flight at the old address; drain it first.
                        if (imem_ack) begin
                            r_req_addr <= branch_addr;
                            r_state    <= S_REQ;
                        end else begin
                            r_state    <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_instr_buf <= imem_rdata;
                        r_state     <= S_HAVE;
                    end
                end
                S_HAVE: begin
                    if (branch_taken) begin
                        r_pc       <= branch_addr;
                        r_req_addr <= branch_addr;
                        r_state    <= S_REQ;
                    end else if (!hazard) begin
                        r_pc       <= w_pc_next;
                        r_req_addr <= w_pc_next;
                        r_state    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (branch_taken) begin
                        r_pc <= branch_addr;
                        if (imem_ack) begin
                            r_req_addr <= branch_addr;
                            r_state    <= S_REQ;
                        end
                    end else if (imem_ack) begin
                        r_req_addr <= r_pc;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = r_req_addr;
        fetch_pc    = '0;
        fetch_instr = NOP_INSTR;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b1;
        if (!rst) begin
            case (r_state)
                S_HAVE: begin
                    fetch_pc    = w_pc_next;
                    fetch_instr = r_instr_buf;
                    ifid_freeze = hazard;
                    ifid_flush  = 1'b0;
                end
                S_REQ, S_DRAIN: begin
                    imem_req    = 1'b1;
                    ifid_freeze = hazard;
                    ifid_flush  = !hazard;
                end
                default: begin
                    imem_req    = 1'b0;
                end
            endcase
            if (branch_taken) begin
                ifid_freeze = 1'b0;
                ifid_flush  = 1'b1;
            end
        end
    end

`ifdef IF_FETCH_CTRL_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_valid_load;

    assign w_valid_load = (r_state == S_HAVE) && !hazard && !branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_valid_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (ifid_freeze) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - vector-table and sequence bench for if_fetch_ctrl.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'hE000_0000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        ifid_freeze;
    logic        ifid_flush;
`ifdef IF_FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .fetch_pc     (fetch_pc),
        .fetch_instr  (fetch_instr),
        .ifid_freeze  (ifid_freeze),
        .ifid_flush   (ifid_flush)
`ifdef IF_FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        hz;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_fpc;
        logic [31:0] e_instr;
        logic        e_frz;
        logic        e_fl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] iw(input int n);
        return 32'h1000_0000 + 32'(n);
    endfunction

    task automatic v(input logic r, input logic hz, input logic br, input logic [31:0] ba,
                     input logic ack, input logic [31:0] rd, input logic req, input logic [31:0] ad,
                     input logic [31:0] fpc, input logic [31:0] ins, input logic frz, input logic fl);
        vec_t t;
        t.rst = r; t.hz = hz; t.br = br; t.baddr = ba; t.ack = ack; t.rdata = rd;
        t.e_req = req; t.e_addr = ad; t.e_fpc = fpc; t.e_instr = ins; t.e_frz = frz; t.e_fl = fl;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Enters and leaves on a falling edge with the DUT in S_REQ at address a.
    task automatic fetch_one(input int k, input int hz, input logic [31:0] a);
        for (int w = 0; w <= k; w++) begin
            imem_ack   = (w == k);
            imem_rdata = 32'h2000_0000 ^ a;
            #1;
            chk($sformatf("seq_req@%h", a), 32'(imem_req), 32'd1);
            chk($sformatf("seq_addr@%h", a), imem_addr, a);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        for (int h = 0; h < hz; h++) begin
            hazard = 1'b1;
            #1;
            chk($sformatf("seq_freeze@%h", a), 32'(ifid_freeze), 32'd1);
            @(negedge clk);
        end
        hazard = 1'b0;
        #1;
        chk($sformatf("seq_fpc@%h", a), fetch_pc, a + 32'd4);
        chk($sformatf("seq_instr@%h", a), fetch_instr, 32'h2000_0000 ^ a);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, then zero-wait fetches
        v(1,0,0,0,0,0,           0,0,0,NOP,0,1);
        v(1,0,0,0,0,0,           0,0,0,NOP,0,1);
        v(0,0,0,0,1,iw(0),       1,0,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,4,iw(0),0,0);
        v(0,0,0,0,1,iw(1),       1,4,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,8,iw(1),0,0);
        v(0,0,0,0,1,iw(2),       1,8,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,12,iw(2),0,0);
        // 3 wait cycles, then 5 hazard cycles in S_HAVE
        v(0,0,0,0,0,0,           1,12,0,NOP,0,1);
        v(0,0,0,0,0,0,           1,12,0,NOP,0,1);
        v(0,0,0,0,0,0,           1,12,0,NOP,0,1);
        v(0,0,0,0,1,iw(3),       1,12,0,NOP,0,1);
        for (int i = 0; i < 5; i++) v(0,1,0,0,0,0, 0,0,16,iw(3),1,0);
        v(0,0,0,0,0,0,           0,0,16,iw(3),0,0);
        v(0,1,0,0,0,0,           1,16,0,NOP,1,0);
        v(0,0,0,0,1,iw(4),       1,16,0,NOP,0,1);
        // branch in S_HAVE under hazard
        v(0,1,1,32'h100,0,0,     0,0,20,iw(4),0,1);
        v(0,0,0,0,0,0,           1,32'h100,0,NOP,0,1);
        v(0,0,0,0,1,iw(5),       1,32'h100,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,32'h104,iw(5),0,0);
        // branch in S_REQ at wait cycle 1 -> drain stale request
        v(0,0,0,0,0,0,           1,32'h104,0,NOP,0,1);
        v(0,0,1,32'h200,0,0,     1,32'h104,0,NOP,0,1);
        v(0,0,0,0,0,0,           1,32'h104,0,NOP,0,1);
        v(0,0,0,0,1,DEAD,        1,32'h104,0,NOP,0,1);
        v(0,0,0,0,1,iw(6),       1,32'h200,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,32'h204,iw(6),0,0);
        // branches during drain, last one coincident with ack
        v(0,0,1,32'h280,0,0,     1,32'h204,0,NOP,0,1);
        v(0,0,1,32'h300,0,0,     1,32'h204,0,NOP,0,1);
        v(0,1,0,0,0,0,           1,32'h204,0,NOP,1,0);
        v(0,0,1,32'h400,1,DEAD,  1,32'h204,0,NOP,0,1);
        v(0,0,0,0,1,iw(7),       1,32'h400,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,32'h404,iw(7),0,0);
        // branch coincident with ack in S_REQ
        v(0,0,1,32'h500,1,DEAD,  1,32'h404,0,NOP,0,1);
        v(0,0,0,0,1,iw(8),       1,32'h500,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,32'h504,iw(8),0,0);
        // PC wrap
        v(0,0,1,32'hFFFF_FFFC,1,DEAD, 1,32'h504,0,NOP,0,1);
        v(0,0,0,0,1,iw(9),       1,32'hFFFF_FFFC,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,0,iw(9),0,0);
        v(0,0,0,0,1,iw(10),      1,0,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,4,iw(10),0,0);
        // reset mid-request overrides hazard and branch
        v(0,0,0,0,0,0,           1,4,0,NOP,0,1);
        v(1,1,1,32'h700,0,0,     0,0,0,NOP,0,1);
        v(0,0,0,0,0,0,           1,0,0,NOP,0,1);
        v(0,0,0,0,1,iw(11),      1,0,0,NOP,0,1);
        v(0,0,0,0,0,0,           0,0,4,iw(11),0,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            hazard       = vecs[i].hz;
            branch_taken = vecs[i].br;
            branch_addr  = vecs[i].baddr;
            imem_ack     = vecs[i].ack;
            imem_rdata   = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_fpc", i), fetch_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d_instr", i), fetch_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_freeze", i), 32'(ifid_freeze), 32'(vecs[i].e_frz));
            chk($sformatf("v%0d_flush", i), 32'(ifid_flush), 32'(vecs[i].e_fl));
        end

        // 10 fetches with mixed latency and 4 hazard cycles, then reset mid-request
        @(negedge clk);
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) fetch_one(n % 3, (n < 4) ? 1 : 0, 32'(n * 4));
`ifdef IF_FETCH_CTRL_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_stall", perf_stall_cnt, 32'd4);
`endif
        imem_ack = 1'b0;
        #1;
        chk("pre_rst_addr", imem_addr, 32'd40);
        rst = 1'b1;
        #1;
        chk("rst_req0", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_req1", 32'(imem_req), 32'd0);
        chk("rst_flush", 32'(ifid_flush), 32'd1);
`ifdef IF_FETCH_CTRL_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
